// File: rtl/ma_stage_if.sv
// Data-memory bus between the MA stage (master) and the memory subsystem (slave).
`timescale 1ns/1ps
interface ma_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [29:0] dmem_adr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/ma_stage.sv
// Memory-access stage: issues aligned loads/stores on the data bus, stalls until
// the ack, formats load data and drives the WB / WB2 forwarding registers.
`timescale 1ns/1ps
module ma_stage (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_ld_ma,
  input  logic              cmd_st_ma,
  input  logic [4:0]        rd_adr_ma,
  input  logic [31:0]       rd_data_ma,
  input  logic              wbk_rd_reg_ma,
  input  logic [31:0]       st_data_ma,
  input  logic [2:0]        ldst_code_ma,
  input  logic              stall_ext,
  input  logic              rst_pipe,
  ma_stage_if.master        dmem,
  output logic              ma_stall,
  output logic [4:0]        rd_adr_wb,
  output logic [31:0]       wbk_data_wb,
  output logic              wbk_rd_reg_wb,
  output logic [4:0]        rd_adr_wb2,
  output logic [31:0]       wbk_data_wb2,
  output logic              wbk_rd_reg_wb2,
  output logic              misalign_ma
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] ld_buf_q;
  logic [4:0]  rd_adr_wb_q, rd_adr_wb2_q;
  logic [31:0] wbk_data_wb_q, wbk_data_wb2_q;
  logic        wbk_rd_reg_wb_q, wbk_rd_reg_wb2_q, misalign_q;

  logic [1:0]  adr_lo;
  logic        is_mem, aligned, misalign, pending, busy_req, advance;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_fmt;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign adr_lo = rd_data_ma[1:0];
  assign is_mem = cmd_ld_ma | cmd_st_ma;

  always_comb begin
    case (ldst_code_ma[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~adr_lo[0];
      default: aligned = (adr_lo == 2'b00);
    endcase
  end

  assign misalign = is_mem & ~aligned;
  assign pending  = is_mem & aligned & (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state_q <= IDLE;
    else if (rst_pipe) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending)       state_d = BUSY;
      BUSY:    if (dmem.dmem_ack) state_d = DONE;
      DONE:    if (!stall_ext)    state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_req = 1'b0;
    case (state_q)
      IDLE:    busy_req = pending;
      BUSY:    busy_req = 1'b1;
      default: busy_req = 1'b0;
    endcase
  end

  // Gated by rst_n so the request drops the instant reset asserts, even while
  // the MA inputs still present an aligned load/store.
  assign dmem.dmem_req = busy_req & rst_n;
  assign ma_stall      = busy_req & rst_n;
  assign advance       = ~stall_ext & ~ma_stall;

  always_comb begin
    case (ldst_code_ma[1:0])
      2'b00: begin
        be_c    = 4'b0001 << adr_lo;
        wdata_c = {4{st_data_ma[7:0]}};
      end
      2'b01: begin
        be_c    = adr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{st_data_ma[15:0]}};
      end
      default: begin
        be_c    = '1;
        wdata_c = st_data_ma;
      end
    endcase
  end

  assign dmem.dmem_we    = cmd_st_ma;
  assign dmem.dmem_adr   = rd_data_ma[31:2];
  assign dmem.dmem_be    = be_c;
  assign dmem.dmem_wdata = wdata_c;

  always_comb begin
    case (adr_lo)
      2'd0:    lane_b = ld_buf_q[7:0];
      2'd1:    lane_b = ld_buf_q[15:8];
      2'd2:    lane_b = ld_buf_q[23:16];
      default: lane_b = ld_buf_q[31:24];
    endcase
    lane_h = adr_lo[1] ? ld_buf_q[31:16] : ld_buf_q[15:0];
    case (ldst_code_ma)
      3'b000:  ld_fmt = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_fmt = {24'h0, lane_b};
      3'b001:  ld_fmt = {{16{lane_h[15]}}, lane_h};
      3'b101:  ld_fmt = {16'h0, lane_h};
      default: ld_fmt = ld_buf_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ld_buf_q <= '0;
    else if (rst_pipe)                         ld_buf_q <= '0;
    else if (state_q == BUSY && dmem.dmem_ack) ld_buf_q <= dmem.dmem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_adr_wb_q      <= '0;
      wbk_data_wb_q    <= '0;
      wbk_rd_reg_wb_q  <= 1'b0;
      rd_adr_wb2_q     <= '0;
      wbk_data_wb2_q   <= '0;
      wbk_rd_reg_wb2_q <= 1'b0;
      misalign_q       <= 1'b0;
    end else if (rst_pipe) begin
      rd_adr_wb_q      <= '0;
      wbk_data_wb_q    <= '0;
      wbk_rd_reg_wb_q  <= 1'b0;
      rd_adr_wb2_q     <= '0;
      wbk_data_wb2_q   <= '0;
      wbk_rd_reg_wb2_q <= 1'b0;
      misalign_q       <= 1'b0;
    end else if (advance) begin
      rd_adr_wb_q      <= rd_adr_ma;
      wbk_data_wb_q    <= cmd_ld_ma ? ld_fmt : rd_data_ma;
      wbk_rd_reg_wb_q  <= wbk_rd_reg_ma & ~cmd_st_ma & ~misalign;
      rd_adr_wb2_q     <= rd_adr_wb_q;
      wbk_data_wb2_q   <= wbk_data_wb_q;
      wbk_rd_reg_wb2_q <= wbk_rd_reg_wb_q;
      misalign_q       <= misalign;
    end else begin
      misalign_q       <= 1'b0;
    end
  end

  assign rd_adr_wb      = rd_adr_wb_q;
  assign wbk_data_wb    = wbk_data_wb_q;
  assign wbk_rd_reg_wb  = wbk_rd_reg_wb_q;
  assign rd_adr_wb2     = rd_adr_wb2_q;
  assign wbk_data_wb2   = wbk_data_wb2_q;
  assign wbk_rd_reg_wb2 = wbk_rd_reg_wb2_q;
  assign misalign_ma    = misalign_q;

endmodule

// File: tb/tb_ma_stage.sv
// Directed + randomized bench for ma_stage against a byte-arithmetic reference model.
`timescale 1ns/1ps
module tb_ma_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_ld_ma, cmd_st_ma;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma;
  logic        wbk_rd_reg_ma;
  logic [31:0] st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        stall_ext, rst_pipe;
  logic        ma_stall;
  logic [4:0]  rd_adr_wb, rd_adr_wb2;
  logic [31:0] wbk_data_wb, wbk_data_wb2;
  logic        wbk_rd_reg_wb, wbk_rd_reg_wb2, misalign_ma;

  ma_stage_if dmem_bus ();

  ma_stage dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma),
    .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma),
    .wbk_rd_reg_ma(wbk_rd_reg_ma), .st_data_ma(st_data_ma),
    .ldst_code_ma(ldst_code_ma), .stall_ext(stall_ext), .rst_pipe(rst_pipe),
    .dmem(dmem_bus), .ma_stall(ma_stall),
    .rd_adr_wb(rd_adr_wb), .wbk_data_wb(wbk_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
    .rd_adr_wb2(rd_adr_wb2), .wbk_data_wb2(wbk_data_wb2), .wbk_rd_reg_wb2(wbk_rd_reg_wb2),
    .misalign_ma(misalign_ma)
  );

  always #5 clk = ~clk;

  int unsigned total = 0, passed = 0;

  // Reference model state
  logic [4:0]  m_adr, m_adr2;
  logic [31:0] m_data, m_data2, m_ld_buf;
  logic        m_reg, m_reg2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int unsigned nbytes(input logic [2:0] c);
    int unsigned k;
    k = 32'(c) % 4;
    if (k == 0) return 1;
    if (k == 1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] c, input logic [31:0] a);
    int unsigned nb, off;
    logic [31:0] v, mask;
    nb = nbytes(c);
    if (nb == 4) return w;
    off  = (a % 4) - ((a % 4) % nb);
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = (w >> (8 * off)) & mask;
    if (c < 3'd4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] c, input logic [31:0] a);
    int unsigned t;
    t = ((32'd1 << nbytes(c)) - 1) << (a % 4);
    return t[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] c, input logic [31:0] s);
    logic [31:0] w;
    int unsigned nb;
    nb = nbytes(c);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = s[8*(i % nb) +: 8];
    return w;
  endfunction

  task automatic model_clear();
    m_adr = '0; m_adr2 = '0; m_data = '0; m_data2 = '0; m_reg = 1'b0; m_reg2 = 1'b0;
    m_ld_buf = '0;
  endtask

  task automatic check_wb(input string tag);
    chk({tag, ".rd_adr_wb"},      32'(rd_adr_wb),      32'(m_adr));
    chk({tag, ".wbk_data_wb"},    wbk_data_wb,         m_data);
    chk({tag, ".wbk_rd_reg_wb"},  32'(wbk_rd_reg_wb),  32'(m_reg));
    chk({tag, ".rd_adr_wb2"},     32'(rd_adr_wb2),     32'(m_adr2));
    chk({tag, ".wbk_data_wb2"},   wbk_data_wb2,        m_data2);
    chk({tag, ".wbk_rd_reg_wb2"}, 32'(wbk_rd_reg_wb2), 32'(m_reg2));
  endtask

  // One MA operation from presentation to WB advance; extra = BUSY cycles before the ack cycle.
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] code,
                        input logic [31:0] rdv, input logic [31:0] sd, input logic rreg,
                        input logic [4:0] radr, input logic [31:0] rdata,
                        input int unsigned extra, input int unsigned dstall);
    int unsigned stalls;
    logic mis, mem;
    mem = ld | st;
    mis = mem && ((rdv % nbytes(code)) != 0);
    @(negedge clk);
    cmd_ld_ma = ld; cmd_st_ma = st; ldst_code_ma = code; rd_data_ma = rdv;
    st_data_ma = sd; wbk_rd_reg_ma = rreg; rd_adr_ma = radr;
    stall_ext = 1'b0; rst_pipe = 1'b0; dmem_bus.dmem_ack = 1'b0;
    #1;
    if (mem && !mis) begin
      chk({tag, ".issue_req"},   32'(dmem_bus.dmem_req), 32'd1);
      chk({tag, ".issue_stall"}, 32'(ma_stall),          32'd1);
      chk({tag, ".we"},          32'(dmem_bus.dmem_we),  32'(st));
      chk({tag, ".adr"},         32'(dmem_bus.dmem_adr), rdv >> 2);
      chk({tag, ".be"},          32'(dmem_bus.dmem_be),  32'(exp_be(code, rdv)));
      if (st) chk({tag, ".wdata"}, dmem_bus.dmem_wdata, exp_wdata(code, sd));
      stalls = 1;
      for (int i = 0; i < int'(extra); i++) begin
        @(negedge clk);
        chk({tag, ".busy_req"}, 32'(dmem_bus.dmem_req), 32'd1);
        if (ma_stall) stalls++;
      end
      @(negedge clk);
      dmem_bus.dmem_rdata = rdata; dmem_bus.dmem_ack = 1'b1;
      chk({tag, ".ack_req"}, 32'(dmem_bus.dmem_req), 32'd1);
      if (ma_stall) stalls++;
      m_ld_buf = rdata;
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b0;
      dmem_bus.dmem_rdata = $urandom;
      chk({tag, ".done_req"},    32'(dmem_bus.dmem_req), 32'd0);
      chk({tag, ".stall_count"}, stalls,                 extra + 2);
      check_wb({tag, ".hold"});
      stall_ext = (dstall != 0);
      for (int i = 0; i < int'(dstall); i++) begin
        @(negedge clk);
        chk({tag, ".done_noreissue"}, 32'(dmem_bus.dmem_req), 32'd0);
        check_wb({tag, ".stall_hold"});
        if (i == int'(dstall) - 1) stall_ext = 1'b0;
      end
    end else begin
      chk({tag, ".noreq"},   32'(dmem_bus.dmem_req), 32'd0);
      chk({tag, ".nostall"}, 32'(ma_stall),          32'd0);
    end
    m_adr2 = m_adr; m_data2 = m_data; m_reg2 = m_reg;
    m_adr  = radr;
    m_data = ld ? load_fmt(m_ld_buf, code, rdv) : rdv;
    m_reg  = rreg & ~st & ~mis;
    @(posedge clk);
    #1;
    check_wb({tag, ".adv"});
    chk({tag, ".misalign"}, 32'(misalign_ma), 32'(mis));
  endtask

  logic [2:0] codes [0:4];

  initial begin
    logic [2:0]  c;
    logic [31:0] a;
    int unsigned kind;
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010; codes[3] = 3'b100; codes[4] = 3'b101;
    model_clear();

    // Reset: an aligned load is presented, yet nothing may be requested
    rst_n = 1'b0; rst_pipe = 1'b0; stall_ext = 1'b1;
    cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = 3'b010; rd_data_ma = 32'h100;
    st_data_ma = '0; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd3;
    dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
    #3;
    chk("rst.req",      32'(dmem_bus.dmem_req), 32'd0);
    chk("rst.stall",    32'(ma_stall),          32'd0);
    chk("rst.misalign", 32'(misalign_ma),       32'd0);
    check_wb("rst");
    @(negedge clk);
    rst_n = 1'b1; cmd_ld_ma = 1'b0;

    // LW 0x100, ack on the third BUSY cycle
    run_op("lw", 1, 0, 3'b010, 32'h100, 32'h0, 1, 5'd7, 32'hDEADBEEF, 2, 0);
    chk("lw.lit", wbk_data_wb, 32'hDEADBEEF);
    run_op("nop1", 0, 0, 3'b000, 32'h55AA0001, 32'h0, 1, 5'd9, 32'h0, 0, 0);
    chk("lw.wb2_lit", wbk_data_wb2, 32'hDEADBEEF);

    // Sub-word loads
    run_op("lb",  1, 0, 3'b000, 32'h103, 32'h0, 1, 5'd1, 32'h80FF_0000, 0, 0);
    chk("lb.lit", wbk_data_wb, 32'hFFFFFF80);
    run_op("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 1, 5'd2, 32'h80FF_0000, 0, 0);
    chk("lbu.lit", wbk_data_wb, 32'h00000080);
    run_op("lh",  1, 0, 3'b001, 32'h102, 32'h0, 1, 5'd3, 32'h80FF_0000, 1, 0);
    chk("lh.lit", wbk_data_wb, 32'hFFFF80FF);

    // Store half, misaligned word load, stalled DONE
    run_op("sh", 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 1, 5'd4, 32'h0, 0, 0);
    chk("sh.rdreg_lit", 32'(wbk_rd_reg_wb), 32'd0);
    run_op("lw_mis", 1, 0, 3'b010, 32'h101, 32'h0, 1, 5'd5, 32'h0, 0, 0);
    run_op("nop2", 0, 0, 3'b000, 32'hCAFE0000, 32'h0, 1, 5'd6, 32'h0, 0, 0);
    run_op("lw_dstall", 1, 0, 3'b010, 32'h108, 32'h0, 1, 5'd8, 32'h01234567, 0, 2);

    // rst_pipe in BUSY, then a late ack that must be ignored
    @(negedge clk);
    cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = 3'b010; rd_data_ma = 32'h300;
    rd_adr_ma = 5'd10; wbk_rd_reg_ma = 1'b1; stall_ext = 1'b0;
    @(negedge clk);
    chk("rp.busy_req", 32'(dmem_bus.dmem_req), 32'd1);
    rst_pipe = 1'b1;
    @(negedge clk);
    rst_pipe = 1'b0; cmd_ld_ma = 1'b0; stall_ext = 1'b1;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hFFFFFFFF;
    model_clear();
    #1;
    chk("rp.req", 32'(dmem_bus.dmem_req), 32'd0);
    check_wb("rp.clear");
    @(negedge clk);
    dmem_bus.dmem_ack = 1'b0;
    chk("rp.late_ack_req", 32'(dmem_bus.dmem_req), 32'd0);
    check_wb("rp.late_ack");
    run_op("rp.reissue", 1, 0, 3'b010, 32'h304, 32'h0, 1, 5'd11, 32'h13579BDF, 0, 0);

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    cmd_ld_ma = 1'b1; ldst_code_ma = 3'b010; rd_data_ma = 32'h400; stall_ext = 1'b0;
    @(negedge clk);
    chk("arst.busy_req", 32'(dmem_bus.dmem_req), 32'd1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("arst.req",   32'(dmem_bus.dmem_req), 32'd0);
    chk("arst.stall", 32'(ma_stall),          32'd0);
    check_wb("arst");
    @(negedge clk);
    cmd_ld_ma = 1'b0; stall_ext = 1'b1; rst_n = 1'b1;
    run_op("arst.ldbuf", 1, 0, 3'b010, 32'h401, 32'h0, 1, 5'd12, 32'h0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      c = codes[$urandom_range(0, 4)];
      a = {20'h0, 12'($urandom_range(0, 4095))};
      if (kind == 0) a = $urandom;
      run_op($sformatf("rnd%0d", n), kind == 1, kind == 2, c, a, $urandom, 1'($urandom),
             5'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
